// File: rtl/mem_arbiter_nch.sv
// N-channel memory arbiter with tag tracking.
// Routes each returned data beat to the channel that issued the load.
module mem_arbiter_nch #(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 0,
  parameter int XLEN    = 32,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CH-1:0][1:0]         ch2ctrl_command,
  input  logic [NUM_CH-1:0][XLEN-1:0]    ch2ctrl_addr,
  input  logic [NUM_CH-1:0][63:0]        ch2ctrl_data,
  output logic [NUM_CH-1:0][3:0]         ctrl2ch_response,
  output logic [NUM_CH-1:0][63:0]        ctrl2ch_data,
  output logic [NUM_CH-1:0][3:0]         ctrl2ch_tag,
  output logic [1:0]                     proc2mem_command,
  output logic [XLEN-1:0]                proc2mem_addr,
  output logic [63:0]                    proc2mem_data,
  input  logic [3:0]                     mem2proc_response,
  input  logic [63:0]                    mem2proc_data,
  input  logic [3:0]                     mem2proc_tag,
  output logic [NUM_CH-1:0]              grant,
  output logic [3:0]                     outstanding,
  output logic                           orphan_err
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gidx;
  logic              gvalid;
  logic              g_act;
  logic [1:0]        gcmd;
  logic              resp_ok;
  logic              alloc;
  logic              ret_hit;
  logic [CH_W-1:0]   ret_owner;
  logic [15:0]       valid_q;
  logic [15:0]       valid_d;
  logic [CH_W-1:0]   owner_q [16];
  logic [3:0]        outst_q;
  logic [3:0]        cnt;
  logic [CH_W:0]     sum;
  logic [CH_W-1:0]   base;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = ch2ctrl_command[i] != BUS_NONE;
    end
  end

  // Scan starts at rr_ptr in round-robin mode, else at channel 0.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    sum    = '0;
    base   = (RR_MODE != 0) ? rr_ptr : '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, base} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (!gvalid && req[sum[CH_W-1:0]]) begin
        gvalid = 1'b1;
        gidx   = sum[CH_W-1:0];
      end
    end
  end

  assign g_act   = gvalid && !reset;
  assign gcmd    = ch2ctrl_command[gidx];
  assign resp_ok = g_act && (mem2proc_response != 4'd0);
  assign alloc   = resp_ok && (gcmd == BUS_LOAD);

  assign ret_hit   = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
  assign ret_owner = owner_q[mem2proc_tag];

  assign grant = g_act ? (NUM_CH'(1) << gidx) : '0;

  assign proc2mem_command = g_act ? gcmd : BUS_NONE;
  assign proc2mem_addr    = g_act ? ch2ctrl_addr[gidx] : '0;
  assign proc2mem_data    = (g_act && gcmd == BUS_STORE) ?
                            ch2ctrl_data[gidx] : 64'd0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl2ch_response[i] = (g_act && gidx == CH_W'(i)) ?
                            mem2proc_response : 4'd0;
      ctrl2ch_tag[i]  = 4'd0;
      ctrl2ch_data[i] = 64'd0;
      if (!reset && ret_hit && ret_owner == CH_W'(i)) begin
        ctrl2ch_tag[i]  = mem2proc_tag;
        ctrl2ch_data[i] = mem2proc_data;
      end
    end
  end

  // A reallocated tag is only a collision if it is not retiring now.
  assign orphan_err = !reset && (
    ((mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag]) ||
    (alloc && valid_q[mem2proc_response] &&
     !(ret_hit && mem2proc_tag == mem2proc_response)));

  always_comb begin
    valid_d = valid_q;
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) valid_d[mem2proc_response] = 1'b1;
    cnt = '0;
    for (int j = 0; j < 16; j++) begin
      cnt = cnt + 4'(valid_d[j]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rr_ptr  <= '0;
      outst_q <= '0;
    end else begin
      valid_q <= valid_d;
      outst_q <= cnt;
      if (resp_ok) begin
        rr_ptr <= (gidx == CH_W'(NUM_CH-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc) owner_q[mem2proc_response] <= gidx;
  end

  assign outstanding = reset ? 4'd0 : outst_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench: fixed-priority 2-channel and round-robin 3-channel.
module tb_mem_arbiter_nch;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] S = 2'd2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [1:0][1:0]  f_cmd;
  logic [1:0][31:0] f_addr;
  logic [1:0][63:0] f_wdat;
  logic [1:0][3:0]  f_rsp;
  logic [1:0][63:0] f_rdat;
  logic [1:0][3:0]  f_rtag;
  logic [1:0]       f_pcmd;
  logic [31:0]      f_paddr;
  logic [63:0]      f_pdata;
  logic [3:0]       f_mrsp;
  logic [63:0]      f_mdat;
  logic [3:0]       f_mtag;
  logic [1:0]       f_grant;
  logic [3:0]       f_out;
  logic             f_orph;

  logic [2:0][1:0]  r_cmd;
  logic [2:0][31:0] r_addr;
  logic [2:0][63:0] r_wdat;
  logic [2:0][3:0]  r_rsp;
  logic [2:0][63:0] r_rdat;
  logic [2:0][3:0]  r_rtag;
  logic [1:0]       r_pcmd;
  logic [31:0]      r_paddr;
  logic [63:0]      r_pdata;
  logic [3:0]       r_mrsp;
  logic [63:0]      r_mdat;
  logic [3:0]       r_mtag;
  logic [2:0]       r_grant;
  logic [3:0]       r_out;
  logic             r_orph;

  mem_arbiter_nch #(.NUM_CH(2), .RR_MODE(0), .XLEN(32)) u_fp (
    .clock(clk), .reset(rst),
    .ch2ctrl_command(f_cmd), .ch2ctrl_addr(f_addr),
    .ch2ctrl_data(f_wdat), .ctrl2ch_response(f_rsp),
    .ctrl2ch_data(f_rdat), .ctrl2ch_tag(f_rtag),
    .proc2mem_command(f_pcmd), .proc2mem_addr(f_paddr),
    .proc2mem_data(f_pdata), .mem2proc_response(f_mrsp),
    .mem2proc_data(f_mdat), .mem2proc_tag(f_mtag),
    .grant(f_grant), .outstanding(f_out), .orphan_err(f_orph)
  );

  mem_arbiter_nch #(.NUM_CH(3), .RR_MODE(1), .XLEN(32)) u_rr (
    .clock(clk), .reset(rst),
    .ch2ctrl_command(r_cmd), .ch2ctrl_addr(r_addr),
    .ch2ctrl_data(r_wdat), .ctrl2ch_response(r_rsp),
    .ctrl2ch_data(r_rdat), .ctrl2ch_tag(r_rtag),
    .proc2mem_command(r_pcmd), .proc2mem_addr(r_paddr),
    .proc2mem_data(r_pdata), .mem2proc_response(r_mrsp),
    .mem2proc_data(r_mdat), .mem2proc_tag(r_mtag),
    .grant(r_grant), .outstanding(r_out), .orphan_err(r_orph)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c0; logic [31:0] a0; logic [63:0] d0;
    logic [1:0]  c1; logic [31:0] a1; logic [63:0] d1;
    logic [3:0]  rsp; logic [3:0] rtag; logic [63:0] rdat;
    logic [1:0]  grant; logic [1:0] pcmd;
    logic [31:0] paddr; logic [63:0] pdata;
    logic [3:0]  r0; logic [3:0] r1;
    logic [3:0]  t0; logic [63:0] o0;
    logic [3:0]  t1; logic [63:0] o1;
    logic        orph; logic [3:0] outst;
  } vec_t;

  typedef struct {
    logic [3:0] rsp;
    logic [2:0] grant;
  } rr_t;

  vec_t vecs [14];
  rr_t  rrv  [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic f_idle();
    f_cmd  = '0; f_addr = '0; f_wdat = '0;
    f_mrsp = '0; f_mdat = '0; f_mtag = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    f_idle();
    r_cmd = '0; r_addr = '0; r_wdat = '0;
    r_mrsp = '0; r_mdat = '0; r_mtag = '0;

    vecs[0]  = '{L,32'h1000,0, L,32'h2000,0, 3,0,0,
                 2'b01,L,32'h1000,0, 3,0, 0,0,0,0, 0,1};
    vecs[1]  = '{N,0,0, L,32'h2000,0, 5,0,0,
                 2'b10,L,32'h2000,0, 0,5, 0,0,0,0, 0,2};
    vecs[2]  = '{N,0,0, N,0,0, 0,5,64'hDEAD,
                 2'b00,N,0,0, 0,0, 0,0,5,64'hDEAD, 0,1};
    vecs[3]  = '{N,0,0, N,0,0, 0,5,64'hDEAD,
                 2'b00,N,0,0, 0,0, 0,0,0,0, 1,1};
    vecs[4]  = '{N,0,0, S,32'h40,64'h55, 7,0,0,
                 2'b10,S,32'h40,64'h55, 0,7, 0,0,0,0, 0,1};
    vecs[5]  = '{N,0,0, N,0,0, 0,7,64'hAAAA,
                 2'b00,N,0,0, 0,0, 0,0,0,0, 1,1};
    vecs[6]  = '{L,32'h3000,0, N,0,0, 2,0,0,
                 2'b01,L,32'h3000,0, 2,0, 0,0,0,0, 0,2};
    vecs[7]  = '{N,0,0, L,32'h4000,0, 2,2,64'hBEEF,
                 2'b10,L,32'h4000,0, 0,2, 2,64'hBEEF,0,0, 0,2};
    vecs[8]  = '{N,0,0, N,0,0, 0,2,64'h1234,
                 2'b00,N,0,0, 0,0, 0,0,2,64'h1234, 0,1};
    vecs[9]  = '{L,32'h5000,0, N,0,0, 3,0,0,
                 2'b01,L,32'h5000,0, 3,0, 0,0,0,0, 1,1};
    vecs[10] = '{L,32'h6000,64'hFF, N,0,0, 0,0,0,
                 2'b01,L,32'h6000,0, 0,0, 0,0,0,0, 0,1};
    vecs[11] = '{N,0,0, N,0,0, 0,3,64'h77,
                 2'b00,N,0,0, 0,0, 3,64'h77,0,0, 0,0};
    vecs[12] = '{N,0,0, N,0,0, 0,0,64'h99,
                 2'b00,N,0,0, 0,0, 0,0,0,0, 0,0};
    vecs[13] = '{S,32'h80,64'h11, L,32'h90,0, 9,0,0,
                 2'b01,S,32'h80,64'h11, 9,0, 0,0,0,0, 0,0};

    rrv[0] = '{4'd1, 3'b001};
    rrv[1] = '{4'd2, 3'b010};
    rrv[2] = '{4'd3, 3'b100};
    rrv[3] = '{4'd4, 3'b001};
    rrv[4] = '{4'd0, 3'b010};
    rrv[5] = '{4'd6, 3'b010};
    rrv[6] = '{4'd7, 3'b100};

    // Outputs forced low while reset is held, even with a live request.
    f_cmd[0] = L; f_addr[0] = 32'h1000; f_mrsp = 4'd3;
    #3;
    chk("rst.grant", f_grant, 0);
    chk("rst.pcmd", f_pcmd, N);
    chk("rst.paddr", f_paddr, 0);
    chk("rst.rsp0", f_rsp[0], 0);
    chk("rst.outst", f_out, 0);
    chk("rst.orph", f_orph, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      f_cmd[0] = vecs[i].c0; f_addr[0] = vecs[i].a0;
      f_wdat[0] = vecs[i].d0;
      f_cmd[1] = vecs[i].c1; f_addr[1] = vecs[i].a1;
      f_wdat[1] = vecs[i].d1;
      f_mrsp = vecs[i].rsp; f_mtag = vecs[i].rtag;
      f_mdat = vecs[i].rdat;
      #1;
      chk($sformatf("v%0d.grant", i), f_grant, vecs[i].grant);
      chk($sformatf("v%0d.pcmd", i), f_pcmd, vecs[i].pcmd);
      chk($sformatf("v%0d.paddr", i), f_paddr, vecs[i].paddr);
      chk($sformatf("v%0d.pdata", i), f_pdata, vecs[i].pdata);
      chk($sformatf("v%0d.rsp0", i), f_rsp[0], vecs[i].r0);
      chk($sformatf("v%0d.rsp1", i), f_rsp[1], vecs[i].r1);
      chk($sformatf("v%0d.tag0", i), f_rtag[0], vecs[i].t0);
      chk($sformatf("v%0d.dat0", i), f_rdat[0], vecs[i].o0);
      chk($sformatf("v%0d.tag1", i), f_rtag[1], vecs[i].t1);
      chk($sformatf("v%0d.dat1", i), f_rdat[1], vecs[i].o1);
      chk($sformatf("v%0d.orph", i), f_orph, vecs[i].orph);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.outst", i), f_out, vecs[i].outst);
      @(negedge clk);
    end

    // Four loads in flight, then an asynchronous reset between edges.
    for (int k = 0; k < 4; k++) begin
      f_idle();
      f_cmd[0] = L;
      f_addr[0] = 32'h100 * (k + 1);
      f_mrsp = 4'(2 * k + 2);
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid.outst4", f_out, 4);
    f_idle();
    f_cmd[0] = L; f_addr[0] = 32'h9000; f_mrsp = 4'd10;
    f_mtag = 4'd2; f_mdat = 64'h42;
    #2;
    rst = 1'b1;
    #1;
    chk("mid.outst", f_out, 0);
    chk("mid.grant", f_grant, 0);
    chk("mid.pcmd", f_pcmd, N);
    chk("mid.paddr", f_paddr, 0);
    chk("mid.rsp0", f_rsp[0], 0);
    chk("mid.tag0", f_rtag[0], 0);
    chk("mid.dat0", f_rdat[0], 0);
    chk("mid.orph", f_orph, 0);
    @(negedge clk);
    f_idle();
    rst = 1'b0;
    @(negedge clk);
    f_mtag = 4'd4; f_mdat = 64'h5A;
    #1;
    chk("post.orph", f_orph, 1);
    chk("post.tag0", f_rtag[0], 0);
    chk("post.tag1", f_rtag[1], 0);
    @(negedge clk);
    f_idle();

    // Round-robin: all three channels load continuously.
    for (int c = 0; c < 3; c++) begin
      r_cmd[c] = L;
      r_addr[c] = 32'hA000 + 32'(c) * 32'h10;
    end
    for (int i = 0; i < 7; i++) begin
      r_mrsp = rrv[i].rsp;
      #1;
      chk($sformatf("rr%0d.grant", i), r_grant, rrv[i].grant);
      for (int c = 0; c < 3; c++) begin
        if (rrv[i].grant[c]) begin
          chk($sformatf("rr%0d.rsp", i), r_rsp[c], rrv[i].rsp);
          chk($sformatf("rr%0d.addr", i), r_paddr,
              32'hA000 + 32'(c) * 32'h10);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("rr.outst", r_out, 6);
    r_cmd = '0;
    r_mrsp = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_nch.md
Name: mem_arbiter_nch

Overview:
- Parametrised successor to the two-port I/D memory mux: arbitrates NUM_CH cache-side request channels onto the single tagged memory bus.
- Unlike a plain mux, it tracks outstanding load tags in a 15-entry tag table and routes each returned data beat only to the channel that issued it.
- Sits between the Icache, Dcache and any prefetch/writeback channels and the memory interface.

Parameters:
- NUM_CH, 2, number of requester channels (2..8); channel 0 = Dcache.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CH_W, $clog2(NUM_CH) (minimum 1), channel-id width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch2ctrl_command  in  NUM_CH x 2  per-channel BUS_NONE/BUS_LOAD/BUS_STORE
- ch2ctrl_addr  in  NUM_CH x XLEN  per-channel address
- ch2ctrl_data  in  NUM_CH x 64  per-channel store data
- ctrl2ch_response  out  NUM_CH x 4  accept tag; nonzero only on the granted channel
- ctrl2ch_data  out  NUM_CH x 64  return data; valid only on the owning channel
- ctrl2ch_tag  out  NUM_CH x 4  return tag; nonzero only on the owning channel
- proc2mem_command  out  2  to memory
- proc2mem_addr  out  XLEN  to memory
- proc2mem_data  out  64  to memory
- mem2proc_response  in  4  nonzero = request accepted, value = tag
- mem2proc_data  in  64  return data
- mem2proc_tag  in  4  nonzero = data return for that tag
- grant  out  NUM_CH  one-hot granted channel, combinational
- outstanding  out  4  count of valid tag-table entries
- orphan_err  out  1  one-cycle pulse on an untracked return or a tag collision

Behaviour:
- Request set: channel i requests when ch2ctrl_command[i] != BUS_NONE.
- Grant, same cycle (combinational):
  - RR_MODE=0: lowest requesting index.
  - RR_MODE=1: first requester at or after rr_ptr, wrapping modulo NUM_CH.
  - No requester: grant=0, proc2mem_command=BUS_NONE, addr=0, data=0.
- Granted channel drives proc2mem_command/addr/data. proc2mem_data is 0 unless the command is BUS_STORE.
- Accept routing: ctrl2ch_response[g] = mem2proc_response; all other channels see 0. A requester with response 0 must hold and retry.
- Round-robin pointer (RR_MODE=1): on posedge, if grant != 0 and mem2proc_response != 0, rr_ptr <= (g+1) mod NUM_CH. Otherwise it holds. It never advances on a rejected request.
- Tag table: 15 entries indexed by tag 1..15, each {valid, ch_id}.
  - Allocate on posedge when the granted command is BUS_LOAD and mem2proc_response != 0: entry[response] <= {1, g}.
  - Stores are never allocated; memory returns no data for them.
- Return: when mem2proc_tag != 0 and entry[mem2proc_tag].valid:
  - ctrl2ch_tag[owner] = mem2proc_tag and ctrl2ch_data[owner] = mem2proc_data, combinational, same cycle.
  - Other channels see tag 0 and data 0.
  - entry is cleared on the following posedge.
- Untracked return (valid=0): no channel sees a tag, no table change, orphan_err=1 that cycle.
- Same-cycle return of tag T and new allocation of T: the return is routed to the old owner; the allocation wins the register update, so the entry ends valid with the new channel.
- Allocation to a tag already valid and not returning this cycle: overwrite it and raise orphan_err.
- outstanding = popcount(valid), registered, range 0..15.
- Reset (asynchronous, immediate):
  - all valid bits 0, rr_ptr 0, outstanding 0.
  - While reset is high, all outputs are forced to 0 (proc2mem_command=BUS_NONE, grant=0, orphan_err=0).
  - Loads in flight when reset asserts are forgotten; their later returns raise orphan_err.
- Tag 0 on response or return is never recorded and never routed.

Test Plan:
- Fixed priority, NUM_CH=2: ch0 LOAD 0x1000 and ch1 LOAD 0x2000 same cycle, response=3 -> grant=01, proc2mem_addr=0x1000, ctrl2ch_response[0]=3, [1]=0, entry3={1,0}, outstanding=1.
- Routing: with entry3 owned by ch0 and entry5 owned by ch1, mem2proc_tag=5, data=0xDEAD -> ctrl2ch_tag[1]=5, data[1]=0xDEAD, ch0 tag/data 0; next cycle entry5 invalid.
- Round-robin, NUM_CH=3: all channels request continuously, every request accepted -> grants 001,010,100,001. If memory rejects the cycle granting ch1 (response=0), ch1 is granted again next cycle.
- Store: ch1 STORE 0x40, data 0x55, response=7 -> proc2mem_data=0x55, no table entry, outstanding unchanged. A later mem2proc_tag=7 -> orphan_err=1, nothing routed.
- Simultaneous return and reallocation of tag 2 (old owner ch0, new load from ch1) -> ch0 receives the data; after the clock entry2={1,1}; outstanding unchanged.
- Reset mid-operation: 4 loads outstanding, assert reset asynchronously between edges -> outstanding=0 and all outputs 0 immediately. After release, a return of an old tag -> orphan_err=1.
